sm3_host_adpt: RTL

Host-side initiator for the SM3 core message interface. Accepts an upstream byte stream, packs it MSB-first into 32-bit words with byte-valid masks and a last flag, and drives them into `sm3_core_top` under `msg_inpt_rdy` flow control. It then captures the 256-bit compression result and returns it downstream as eight 32-bit words. It is the synthesizable replacement for the bench-side stimulus driver and supports the 32-bit input build (`SM3_INPT_DW_32`) only.

---
 rtl/sm3_adpt_pkg.sv | 33 +++
 rtl/sm3_cfg.v | 12 +
 rtl/sm3_dgst_ser.sv | 65 ++++++
 rtl/sm3_host_adpt.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sm3_adpt_pkg.sv
// Shared types and constants for the SM3 host adapter.
//   adpt_state_e : adapter FSM states
//   MASK_*       : MSB-first valid-byte masks for 1..4 bytes
//   DGST_WORDS   : number of 32-bit digest words returned downstream
package sm3_adpt_pkg;

    typedef enum logic [1:0] {
        ST_PACK     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DOUT     = 2'd3
    } adpt_state_e;

    localparam logic [3:0] MASK_1B = 4'b1000;
    localparam logic [3:0] MASK_2B = 4'b1100;
    localparam logic [3:0] MASK_3B = 4'b1110;
    localparam logic [3:0] MASK_4B = 4'b1111;

    localparam int DGST_WORDS = 8;

    // Mask for a word whose final byte lands in lane cnt.
    function automatic logic [3:0] lane_mask(input logic [1:0] cnt);
        logic [3:0] m;
        case (cnt)
            2'd0:    m = MASK_1B;
            2'd1:    m = MASK_2B;
            2'd2:    m = MASK_3B;
            default: m = MASK_4B;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sm3_cfg.v
// Build configuration for the SM3 host adapter.
//   SM3_INPT_DW_32         : 32-bit message input build (the only build supported)
//   SM3_HOST_ADPT_STAT_EN  : optional statistics counters on sm3_host_adpt
//                            (left undefined here; define it to enable)
`ifndef SM3_CFG_V
`define SM3_CFG_V

`ifndef SM3_INPT_DW_32
`define SM3_INPT_DW_32
`endif

`endif

// File: rtl/sm3_dgst_ser.sv
// Digest serializer: captures the 256-bit compression result and returns it
// as eight 32-bit words, word 0 from [255:224], under valid/ready.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 capture strobe from parent FSM (one cycle)
//   res_in[255:0]         digest to capture
//   dgst_d[31:0]          current digest word (registered)
//   dgst_vld, dgst_lst    word valid / final word marker (registered)
//   dgst_rdy              downstream ready
//   done                  final-word handshake strobe back to parent
module sm3_dgst_ser
    import sm3_adpt_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] res_in,
    output logic [31:0]  dgst_d,
    output logic         dgst_vld,
    output logic         dgst_lst,
    input  logic         dgst_rdy,
    output logic         done
);

    localparam logic [2:0] LAST_IDX = 3'(DGST_WORDS - 1);

    logic [255:0] res_q;
    logic [2:0]   idx;
    logic [2:0]   idx_nxt;
    logic [7:0]   sel_lsb;
    logic         xfer;

    assign xfer    = dgst_vld && dgst_rdy;
    assign done    = xfer && (idx == LAST_IDX);
    assign idx_nxt = idx + 3'd1;
    // Word n sits at bit offset 32*(7-n); for 3 bits, 7-n is ~n.
    assign sel_lsb = {~idx_nxt, 5'b00000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            idx      <= '0;
            dgst_d   <= '0;
            dgst_vld <= 1'b0;
            dgst_lst <= 1'b0;
        end else if (start) begin
            res_q    <= res_in;
            idx      <= '0;
            dgst_d   <= res_in[255:224];
            dgst_vld <= 1'b1;
            dgst_lst <= 1'b0;
        end else if (done) begin
            res_q    <= '0;
            idx      <= '0;
            dgst_d   <= '0;
            dgst_vld <= 1'b0;
            dgst_lst <= 1'b0;
        end else if (xfer) begin
            idx      <= idx_nxt;
            dgst_d   <= res_q[sel_lsb +: 32];
            dgst_lst <= (idx_nxt == LAST_IDX);
        end
    end

endmodule

// File: rtl/sm3_host_adpt.sv
// Host-side initiator for the SM3 core message interface (32-bit input build).
// Packs an upstream byte stream MSB-first into 32-bit words with valid-byte
// masks and a last flag, feeds them to the core, then returns the captured
// 256-bit digest as eight 32-bit words.
// Optional feature macro: SM3_HOST_ADPT_STAT_EN (adds stat_msg_cnt/stat_drop_cnt).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   s_byte_d/vld/lst, s_byte_rdy        upstream byte stream
//   msg_inpt_d/vld_byte/vld/lst/rdy     word interface to sm3_core_top
//   cmprss_otpt_vld, cmprss_otpt_res    digest result pulse from core
//   dgst_d/vld/lst/rdy                  downstream digest words
//   busy                                high unless idle between messages
//
// state       | meaning
// ------------+-------------------------------------------------
// ST_PACK     | accepting bytes into the packing buffer
// ST_SEND     | holding a packed word until the core takes it
// ST_WAIT_RES | message sent, waiting for the compression result
// ST_DOUT     | serializing the digest downstream
`include "sm3_cfg.v"

module sm3_host_adpt
    import sm3_adpt_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_byte_d,
    input  logic         s_byte_vld,
    input  logic         s_byte_lst,
    output logic         s_byte_rdy,
    output logic [31:0]  msg_inpt_d,
    output logic [3:0]   msg_inpt_vld_byte,
    output logic         msg_inpt_vld,
    output logic         msg_inpt_lst,
    input  logic         msg_inpt_rdy,
    input  logic         cmprss_otpt_vld,
    input  logic [255:0] cmprss_otpt_res,
    output logic [31:0]  dgst_d,
    output logic         dgst_vld,
    output logic         dgst_lst,
    input  logic         dgst_rdy,
    output logic         busy
`ifdef SM3_HOST_ADPT_STAT_EN
    ,
    output logic [31:0]  stat_msg_cnt,
    output logic [15:0]  stat_drop_cnt
`endif
);

    adpt_state_e state;
    logic [1:0]  byte_cnt;
    logic [31:0] pack_buf;
    logic [31:0] word_nxt;
    logic        dgst_start;
    logic        dgst_done;

    assign s_byte_rdy = (state == ST_PACK);
    assign busy       = !((state == ST_PACK) && (byte_cnt == 2'd0));
    assign dgst_start = (state == ST_WAIT_RES) && cmprss_otpt_vld;

    // Lane 0 is [31:24]; lane n starts at bit 8*(3-n), i.e. {~n, 3'b0}.
    // Lanes above byte_cnt are always zero because pack_buf is cleared
    // whenever a word is latched.
    always_comb begin
        word_nxt = pack_buf;
        word_nxt[{~byte_cnt, 3'b000} +: 8] = s_byte_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_PACK;
            byte_cnt          <= '0;
            pack_buf          <= '0;
            msg_inpt_d        <= '0;
            msg_inpt_vld_byte <= 4'b0000;
            msg_inpt_vld      <= 1'b0;
            msg_inpt_lst      <= 1'b0;
        end else begin
            case (state)
                ST_PACK: begin
                    if (s_byte_vld) begin
                        if ((byte_cnt == 2'd3) || s_byte_lst) begin
                            msg_inpt_d        <= word_nxt;
                            msg_inpt_vld_byte <= lane_mask(byte_cnt);
                            msg_inpt_vld      <= 1'b1;
                            msg_inpt_lst      <= s_byte_lst;
                            pack_buf          <= '0;
                            byte_cnt          <= '0;
                            state             <= ST_SEND;
                        end else begin
                            pack_buf <= word_nxt;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                ST_SEND: begin
                    if (msg_inpt_rdy) begin
                        msg_inpt_vld <= 1'b0;
                        msg_inpt_lst <= 1'b0;
                        state        <= msg_inpt_lst ? ST_WAIT_RES : ST_PACK;
                    end
                end
                ST_WAIT_RES: begin
                    if (cmprss_otpt_vld) begin
                        state <= ST_DOUT;
                    end
                end
                ST_DOUT: begin
                    if (dgst_done) begin
                        state <= ST_PACK;
                    end
                end
                default: state <= ST_PACK;
            endcase
        end
    end

    sm3_dgst_ser u_dgst_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (dgst_start),
        .res_in   (cmprss_otpt_res),
        .dgst_d   (dgst_d),
        .dgst_vld (dgst_vld),
        .dgst_lst (dgst_lst),
        .dgst_rdy (dgst_rdy),
        .done     (dgst_done)
    );

`ifdef SM3_HOST_ADPT_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_msg_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (dgst_done) begin
                stat_msg_cnt <= stat_msg_cnt + 32'd1;
            end
            if (cmprss_otpt_vld && (state != ST_WAIT_RES)) begin
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
